// File: rtl/sequencer_pkg.sv
// Shared encodings for the phase sequencer: states, phase codes, opcode fields.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_P4   = 3'd4,
    ST_P5   = 3'd5,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [2:0] PH_IDLE = 3'b000;
  localparam logic [2:0] PH_1    = 3'b001;
  localparam logic [2:0] PH_2    = 3'b010;
  localparam logic [2:0] PH_3    = 3'b011;
  localparam logic [2:0] PH_4    = 3'b100;
  localparam logic [2:0] PH_5    = 3'b101;

  localparam logic [1:0] OP_ALU      = 2'b11;
  localparam logic [3:0] SUB_HLT     = 4'b1111;
  localparam logic [3:0] FLAG_LO_MAX = 4'b0101;
  localparam logic [3:0] FLAG_HI_MIN = 4'b1000;
  localparam logic [3:0] FLAG_HI_MAX = 4'b1011;

  function automatic logic is_hlt(input logic [15:0] ir);
    return (ir[15:14] == OP_ALU) && (ir[7:4] == SUB_HLT);
  endfunction

  // ALU sub-ops 0..5 and 8..11 update the condition flags.
  function automatic logic sets_flags(input logic [15:0] ir);
    return (ir[15:14] == OP_ALU) &&
           ((ir[7:4] <= FLAG_LO_MAX) ||
            ((ir[7:4] >= FLAG_HI_MIN) && (ir[7:4] <= FLAG_HI_MAX)));
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse.
// Latency: button rising before edge k gives a pulse sampled by downstream logic at edge k+2.
// Backpressure: none; a pulse is produced for every synchronized rising edge.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  // sr[1:0] is the metastability chain, sr[2] holds the previous synchronized level.
  logic [2:0] sr;

  // Shift the raw button through the synchronizer and history flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= 3'b000;
    end else begin
      sr <= {sr[1:0], btn};
    end
  end

  assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with run/step control, IR, flag latch and retire counter.
// Latency: one phase per clock; button edges act two clocks after their first sampling edge.
// Backpressure: none; step edges ignored outside IDLE, run edges ignored in HALT.
module phase_sequencer
  import sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic [15:0] mem_data,
  input  logic [3:0]  flags_in,
  output logic [2:0]  phase,
  output logic [15:0] instruction,
  output logic        S,
  output logic        Z,
  output logic        C,
  output logic        V,
  output logic        running,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t state;
  logic   stop_pending;
  logic   run_pulse;
  logic   step_pulse;

  btn_sync u_run_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (run_btn),
    .pulse (run_pulse)
  );

  btn_sync u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // Sequencer FSM with registered phase, IR, flags, run/halt status and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      phase        <= PH_IDLE;
      instruction  <= 16'h0000;
      {S, Z, C, V} <= 4'b0000;
      running      <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= 16'h0000;
      stop_pending <= 1'b0;
    end else begin
      // A run edge during a running instruction requests a stop after P5.
      if (run_pulse && running && (state inside {ST_P1, ST_P2, ST_P3, ST_P4})) begin
        stop_pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (run_pulse) begin
            running <= 1'b1;
            state   <= ST_P1;
            phase   <= PH_1;
          end else if (step_pulse) begin
            state <= ST_P1;
            phase <= PH_1;
          end
        end
        ST_P1: begin
          instruction <= mem_data;
          state       <= ST_P2;
          phase       <= PH_2;
        end
        ST_P2: begin
          if (is_hlt(instruction)) begin
            state        <= ST_HALT;
            phase        <= PH_IDLE;
            halted       <= 1'b1;
            running      <= 1'b0;
            stop_pending <= 1'b0;
            instr_count  <= instr_count + 16'd1;
          end else begin
            state <= ST_P3;
            phase <= PH_3;
          end
        end
        ST_P3: begin
          if (sets_flags(instruction)) begin
            {S, Z, C, V} <= flags_in;
          end
          state <= ST_P4;
          phase <= PH_4;
        end
        ST_P4: begin
          state <= ST_P5;
          phase <= PH_5;
        end
        ST_P5: begin
          instr_count <= instr_count + 16'd1;
          // A run edge landing in P5 itself also counts as a stop request.
          if (running && !stop_pending && !run_pulse) begin
            state <= ST_P1;
            phase <= PH_1;
          end else begin
            state        <= ST_IDLE;
            phase        <= PH_IDLE;
            running      <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        ST_HALT: begin
          state   <= ST_HALT;
          phase   <= PH_IDLE;
          halted  <= 1'b1;
          running <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          phase <= PH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: stepped instruction table plus run/halt/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_btn;
  logic        step_btn;
  logic [15:0] mem_word;
  logic [15:0] mem_data;
  logic [3:0]  flags_in;
  logic        alt_mode;
  logic [2:0]  phase;
  logic [15:0] instruction;
  logic        S, Z, C, V;
  logic        running;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] mem;
    logic [3:0]  fl;
    logic [3:0]  exp_flags;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];
  logic [2:0] exp_seq [5];

  always #5 clk = ~clk;

  // Alternating instruction memory for the continuous-run test.
  always_comb mem_data = alt_mode ? (instr_count[0] ? 16'hC050 : 16'hC040) : mem_word;

  phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .mem_data    (mem_data),
    .flags_in    (flags_in),
    .phase       (phase),
    .instruction (instruction),
    .S           (S),
    .Z           (Z),
    .C           (C),
    .V           (V),
    .running     (running),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
    int n = 0;
    while (phase !== p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (phase !== p) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, phase %b expected %b", name, phase, p);
    end
  endtask

  task automatic wait_count(input logic [15:0] c, input int budget, input string name);
    int n = 0;
    while (instr_count !== c && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (instr_count !== c) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, instr_count %h expected %h", name, instr_count, c);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic step_instr(input string name);
    step_btn = 1'b1;
    wait_phase(3'b001, 6, {name, " start"});
    step_btn = 1'b0;
    wait_phase(3'b000, 10, {name, " end"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    mem_word = 16'h0000;
    flags_in = 4'b0000;
    alt_mode = 1'b0;

    vecs[0] = '{16'h8000, 4'b1111, 4'b0000, 16'd1};
    vecs[1] = '{16'hC050, 4'b1010, 4'b1010, 16'd2};
    vecs[2] = '{16'hC060, 4'b0001, 4'b1010, 16'd3};
    vecs[3] = '{16'hC080, 4'b0011, 4'b0011, 16'd4};
    vecs[4] = '{16'hC0B0, 4'b1100, 4'b1100, 16'd5};
    vecs[5] = '{16'hC0C0, 4'b0110, 4'b1100, 16'd6};
    vecs[6] = '{16'h40F0, 4'b0001, 4'b1100, 16'd7};
    vecs[7] = '{16'hC000, 4'b0000, 4'b0000, 16'd8};
    exp_seq[0] = 3'b010;
    exp_seq[1] = 3'b011;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b101;
    exp_seq[4] = 3'b000;

    // Reset values, applied asynchronously.
    #2 rst = 1'b0;
    #1;
    chk("rst phase", {13'd0, phase}, 16'h0000);
    chk("rst ir", instruction, 16'h0000);
    chk("rst flags", {12'd0, S, Z, C, V}, 16'h0000);
    chk("rst count", instr_count, 16'h0000);
    chk("rst running", {15'd0, running}, 16'h0000);
    chk("rst halted", {15'd0, halted}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle after reset", {13'd0, phase}, 16'h0000);

    // Single step of an ADD, watching every phase.
    mem_word = 16'hC040;
    flags_in = 4'b0100;
    step_btn = 1'b1;
    wait_phase(3'b001, 6, "A step start");
    chk("A phase P1", {13'd0, phase}, 16'h0001);
    step_btn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("A phase seq %0d", i), {13'd0, phase}, {13'd0, exp_seq[i]});
    end
    chk("A ir", instruction, 16'hC040);
    chk("A Z", {15'd0, Z}, 16'h0001);
    chk("A flags", {12'd0, S, Z, C, V}, 16'h0004);
    chk("A count", instr_count, 16'h0001);
    chk("A running", {15'd0, running}, 16'h0000);

    // Table of stepped instructions exercising the flag-setting decode.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_word = vecs[i].mem;
      flags_in = vecs[i].fl;
      step_instr($sformatf("B%0d", i));
      chk($sformatf("B%0d ir", i), instruction, vecs[i].mem);
      chk($sformatf("B%0d flags", i), {12'd0, S, Z, C, V}, {12'd0, vecs[i].exp_flags});
      chk($sformatf("B%0d count", i), instr_count, vecs[i].exp_cnt);
      chk($sformatf("B%0d running", i), {15'd0, running}, 16'h0000);
      repeat (3) @(negedge clk);
    end

    // Continuous run, then a stop request in P3.
    do_reset();
    alt_mode = 1'b1;
    flags_in = 4'b0010;
    run_btn  = 1'b1;
    wait_phase(3'b001, 6, "C run start");
    run_btn = 1'b0;
    wait_count(16'd3, 40, "C three retired");
    chk("C running", {15'd0, running}, 16'h0001);
    chk("C phase P1", {13'd0, phase}, 16'h0001);
    chk("C ir", instruction, 16'hC040);
    chk("C flags", {12'd0, S, Z, C, V}, 16'h0002);
    wait_phase(3'b011, 10, "C reach P3");
    run_btn = 1'b1;
    wait_phase(3'b000, 10, "C stop");
    run_btn = 1'b0;
    chk("C stop running", {15'd0, running}, 16'h0000);
    chk("C stop count", instr_count, 16'd4);
    chk("C stop ir", instruction, 16'hC050);
    repeat (8) @(negedge clk);
    chk("C stays idle", {13'd0, phase}, 16'h0000);
    chk("C count held", instr_count, 16'd4);
    alt_mode = 1'b0;

    // HLT: enter HALT after P2 and ignore further buttons.
    do_reset();
    mem_word = 16'hC0F0;
    run_btn  = 1'b1;
    wait_phase(3'b001, 6, "D run start");
    run_btn = 1'b0;
    @(negedge clk);
    chk("D phase P2", {13'd0, phase}, 16'h0002);
    @(negedge clk);
    chk("D halt phase", {13'd0, phase}, 16'h0000);
    chk("D halted", {15'd0, halted}, 16'h0001);
    chk("D count", instr_count, 16'd1);
    chk("D running", {15'd0, running}, 16'h0000);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    run_btn  = 1'b0;
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("D still halted", {15'd0, halted}, 16'h0001);
    chk("D still phase", {13'd0, phase}, 16'h0000);
    chk("D still count", instr_count, 16'd1);
    rst = 1'b0;
    #1;
    chk("D rst halted", {15'd0, halted}, 16'h0000);
    chk("D rst count", instr_count, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous run and step: run wins; reset in P4 aborts the instruction.
    do_reset();
    mem_word = 16'hC040;
    flags_in = 4'b1000;
    run_btn  = 1'b1;
    step_btn = 1'b1;
    wait_phase(3'b001, 6, "E start");
    run_btn  = 1'b0;
    step_btn = 1'b0;
    chk("E running", {15'd0, running}, 16'h0001);
    wait_phase(3'b100, 6, "E reach P4");
    chk("E ir", instruction, 16'hC040);
    chk("E flags", {12'd0, S, Z, C, V}, 16'h0008);
    chk("E count", instr_count, 16'h0000);
    rst = 1'b0;
    #1;
    chk("E rst phase", {13'd0, phase}, 16'h0000);
    chk("E rst ir", instruction, 16'h0000);
    chk("E rst flags", {12'd0, S, Z, C, V}, 16'h0000);
    chk("E rst count", instr_count, 16'h0000);
    chk("E rst running", {15'd0, running}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("E idle after rst", {13'd0, phase}, 16'h0000);

    // Counter wrap from FFFF.
    do_reset();
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    @(negedge clk);
    chk("F preload", instr_count, 16'hFFFF);
    mem_word = 16'h0000;
    step_instr("F");
    chk("F wrap", instr_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
